// File: rtl/demux_capture.sv
`default_nettype none
// ============================================================================
//  Module      : demux_capture
//  Description : Serial-to-parallel select-line capture. Manual mode writes
//                one channel register by address; auto mode walks an
//                internal channel counter across a full frame into a shadow
//                register and publishes it to out[] atomically.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_capture #(
    parameter int N_CH = 7,
    parameter int AW   = 3,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din,
    input  logic [AW-1:0]   addr,
    input  logic            wr_en,
    input  logic            start,
    output logic [N_CH-1:0] out,
    output logic [AW-1:0]   addr_cnt,
    output logic            busy,
    output logic            frame_valid,
    output logic            err
);

    // Hold counter needs at least one bit even when every clock is a sample.
    localparam int              c_hold_w    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD - 1);
    localparam logic [AW-1:0]   c_last_ch   = AW'(N_CH - 1);
    // One extra bit so N_CH == 2**AW still compares correctly.
    localparam logic [AW:0]     c_n_ch      = (AW + 1)'(N_CH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [N_CH-1:0]     r_out;
    // The last channel goes straight from din to out, so it needs no shadow.
    logic [N_CH-2:0]     r_shadow;
    logic [AW-1:0]       r_addr_cnt;
    logic [c_hold_w-1:0] r_hold;
    logic                r_frame_valid;
    logic                r_err;

    logic w_addr_ok;
    logic w_bit_last;
    logic w_frame_end;

    assign w_addr_ok   = ({1'b0, addr} < c_n_ch);
    assign w_bit_last  = (r_hold == c_hold_last);
    assign w_frame_end = w_bit_last && (r_addr_cnt == c_last_ch);

    assign out         = r_out;
    assign addr_cnt    = r_addr_cnt;
    assign busy        = (r_state != c_st_idle);
    assign frame_valid = r_frame_valid;
    assign err         = r_err;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (start) w_state_next = c_st_shift;
            c_st_shift: if (w_frame_end) w_state_next = c_st_done;
            c_st_done:  w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // Registered status pulses: err for any rejected write, frame_valid
    // for the single DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err         <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            r_err         <= wr_en && ((r_state != c_st_idle) || start || !w_addr_ok);
            r_frame_valid <= (r_state == c_st_shift) && w_frame_end;
        end
    end

    // Channel datapath: manual writes, frame shifting and atomic publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out      <= '0;
            r_shadow   <= '0;
            r_addr_cnt <= '0;
            r_hold     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_addr_cnt <= '0;
                        r_hold     <= '0;
                    end else if (wr_en && w_addr_ok) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (addr == AW'(i)) r_out[i] <= din;
                        end
                    end
                end
                c_st_shift: begin
                    if (w_bit_last) begin
                        r_hold <= '0;
                        for (int i = 0; i < N_CH - 1; i++) begin
                            if (r_addr_cnt == AW'(i)) r_shadow[i] <= din;
                        end
                        if (r_addr_cnt == c_last_ch) begin
                            r_out <= {din, r_shadow};
                        end else begin
                            r_addr_cnt <= r_addr_cnt + AW'(1);
                        end
                    end else begin
                        r_hold <= r_hold + c_hold_w'(1);
                    end
                end
                c_st_done: begin
                    r_addr_cnt <= '0;
                end
                default: begin
                    r_addr_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_capture
//  Description : Directed bench for demux_capture; one instance with HOLD=1
//                and one with HOLD=3 share a clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_capture;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // HOLD = 1 instance
    logic       rst1, din1, wr1, start1;
    logic [2:0] addr1;
    logic [6:0] out1;
    logic [2:0] cnt1;
    logic       busy1, fv1, err1;

    // HOLD = 3 instance
    logic       rst3, din3, wr3, start3;
    logic [2:0] addr3;
    logic [6:0] out3;
    logic [2:0] cnt3;
    logic       busy3, fv3, err3;

    int n_cmp = 0;
    int n_err = 0;

    demux_capture #(.N_CH(7), .AW(3), .HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst1), .din(din1), .addr(addr1), .wr_en(wr1),
        .start(start1), .out(out1), .addr_cnt(cnt1), .busy(busy1),
        .frame_valid(fv1), .err(err1)
    );

    demux_capture #(.N_CH(7), .AW(3), .HOLD(3)) u_dut3 (
        .clk(clk), .rst(rst3), .din(din3), .addr(addr3), .wr_en(wr3),
        .start(start3), .out(out3), .addr_cnt(cnt3), .busy(busy3),
        .frame_valid(fv3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] pat4 = 7'b1001101;
    logic [6:0] pat5 = 7'b0010110;
    logic [6:0] pat6 = 7'b1101011;

    initial begin
        rst1 = 1'b1; din1 = 1'b0; wr1 = 1'b0; start1 = 1'b0; addr1 = 3'd0;
        rst3 = 1'b1; din3 = 1'b0; wr3 = 1'b0; start3 = 1'b0; addr3 = 3'd0;
        tick();
        tick();
        check("rst_out",  32'(out1), 32'd0);
        check("rst_cnt",  32'(cnt1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_fv",   32'(fv1), 32'd0);
        check("rst_err",  32'(err1), 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        tick();

        // T2 manual write and clear
        addr1 = 3'd2; din1 = 1'b1; wr1 = 1'b1;
        tick();
        check("t2_set", 32'(out1), 32'b0000100);
        check("t2_err", 32'(err1), 32'd0);
        din1 = 1'b0;
        tick();
        check("t2_clr", 32'(out1), 32'd0);

        // T3 out-of-range address
        addr1 = 3'd6; din1 = 1'b1;
        tick();
        check("t3_pre", 32'(out1), 32'b1000000);
        addr1 = 3'd7; din1 = 1'b0;
        tick();
        check("t3_err",  32'(err1), 32'd1);
        check("t3_hold", 32'(out1), 32'b1000000);
        wr1 = 1'b0;
        tick();
        check("t3_err_drop", 32'(err1), 32'd0);
        check("t3_hold2",    32'(out1), 32'b1000000);

        // T1 async reset mid-cycle with out=0x55 and err pending
        wr1 = 1'b1; din1 = 1'b1;
        for (int a = 0; a < 6; a += 2) begin
            addr1 = 3'(a);
            tick();
        end
        check("t1_pre55", 32'(out1), 32'h55);
        addr1 = 3'd7;
        tick();
        check("t1_pre_err", 32'(err1), 32'd1);
        #2 rst1 = 1'b1;
        #1;
        check("t1_out",  32'(out1), 32'd0);
        check("t1_busy", 32'(busy1), 32'd0);
        check("t1_err",  32'(err1), 32'd0);
        wr1 = 1'b0; din1 = 1'b0; addr1 = 3'd0;
        #2 rst1 = 1'b0;
        tick();

        // T4 auto frame, HOLD=1
        start1 = 1'b1;
        tick();
        check("t4_busy0", 32'(busy1), 32'd1);
        check("t4_cnt0",  32'(cnt1), 32'd0);
        start1 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            din1 = pat4[k];
            tick();
            check("t4_out", 32'(out1), (k < 6) ? 32'd0 : 32'(pat4));
            check("t4_cnt", 32'(cnt1), (k < 6) ? 32'(k + 1) : 32'd6);
            check("t4_fv",  32'(fv1), (k < 6) ? 32'd0 : 32'd1);
            check("t4_busy", 32'(busy1), 32'd1);
        end
        din1 = 1'b0;
        tick();
        check("t4_fv_end",   32'(fv1), 32'd0);
        check("t4_busy_end", 32'(busy1), 32'd0);
        check("t4_cnt_end",  32'(cnt1), 32'd0);
        check("t4_out_held", 32'(out1), 32'(pat4));

        // T5 start and wr_en collisions during SHIFT
        start1 = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            din1 = pat5[k];
            if (k == 2) begin
                start1 = 1'b1; wr1 = 1'b1; addr1 = 3'd0;
            end else begin
                start1 = 1'b0; wr1 = 1'b0;
            end
            tick();
            check("t5_err", 32'(err1), (k == 2) ? 32'd1 : 32'd0);
            check("t5_cnt", 32'(cnt1), (k < 6) ? 32'(k + 1) : 32'd6);
            check("t5_out", 32'(out1), (k < 6) ? 32'(pat4) : 32'(pat5));
        end
        check("t5_fv", 32'(fv1), 32'd1);
        din1 = 1'b0;
        tick();
        check("t5_idle", 32'(busy1), 32'd0);

        // start and wr_en together in IDLE: start wins, write dropped, err
        start1 = 1'b1; wr1 = 1'b1; addr1 = 3'd0; din1 = 1'b1;
        tick();
        check("tc_busy", 32'(busy1), 32'd1);
        check("tc_err",  32'(err1), 32'd1);
        check("tc_out",  32'(out1), 32'(pat5));
        start1 = 1'b0; wr1 = 1'b0; din1 = 1'b0;
        repeat (7) tick();
        check("tc_frame", 32'(out1), 32'd0);
        check("tc_fv",    32'(fv1), 32'd1);
        tick();

        // T6 reset mid-frame, HOLD=3
        addr3 = 3'd1; din3 = 1'b1; wr3 = 1'b1;
        tick();
        wr3 = 1'b0;
        check("t6_pre", 32'(out3), 32'd2);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            din3 = pat6[(e - 1) / 3];
            tick();
            check("t6_cnt", 32'(cnt3), 32'(e / 3));
            check("t6_out", 32'(out3), 32'd2);
        end
        #2 rst3 = 1'b1;
        #1;
        check("t6_rst_out",  32'(out3), 32'd0);
        check("t6_rst_cnt",  32'(cnt3), 32'd0);
        check("t6_rst_busy", 32'(busy3), 32'd0);
        #2 rst3 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("t6_no_fv", 32'(fv3), 32'd0);
        end
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            din3 = pat6[(e - 1) / 3];
            tick();
            check("t6_fv",  32'(fv3), (e == 21) ? 32'd1 : 32'd0);
            check("t6_out2", 32'(out3), (e == 21) ? 32'(pat6) : 32'd0);
        end
        tick();
        check("t6_fv_end",   32'(fv3), 32'd0);
        check("t6_busy_end", 32'(busy3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
